sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Single-clock synchronous FIFO that buffers DATA_WIDTH-bit words between a producer and a consumer in the same clock domain.
- Provides registered full/empty status flags and a registered read-data output.
- Leaf storage block in the FIFO verification environment. The bench drives it through the fifo interface, and assertions probe the internal write pointer.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out in bits.
- DEPTH, 16, number of storage entries; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), derived pointer index width; not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Wr_enable  input  1  write request; data_in is captured when accepted.
- Read_enable  input  1  read request.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when DEPTH entries are stored.
- empty  output  1  high when 0 entries are stored.

Behaviour:
- Reset is synchronous and active-high: sampled at posedge clk. The following take effect at that edge:
  - write_ptr=0, read_ptr=0, count=0.
  - data_out=0, empty=1, full=0.
  - Memory contents are not cleared.
- Reset asserted mid-operation discards all stored data at that edge. Wr_enable and Read_enable are ignored in any cycle where reset=1.
- Internal registers:
  - write_ptr and read_ptr, ADDR_W bits each. write_ptr keeps exactly this name so hierarchical probes resolve.
  - count, ADDR_W+1 bits, range 0..DEPTH.
- Accepted write: wr_ok = Wr_enable && !full, evaluated on the current registered flags.
  - On wr_ok, at the edge: mem[write_ptr] <= data_in; write_ptr <= write_ptr+1.
- Accepted read: rd_ok = Read_enable && !empty.
  - On rd_ok, at the edge: data_out <= mem[read_ptr]; read_ptr <= read_ptr+1.
- Read latency: data_out is valid 1 clock after the Read_enable edge.
- data_out holds its last value when no read is accepted, including a read attempted while empty.
- Pointers wrap modulo DEPTH (DEPTH-1 -> 0) by natural ADDR_W-bit overflow.
- count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither are accepted.
- Flags are registered and derived from the next count: full <= (count_next==DEPTH); empty <= (count_next==0). Flags update in the same cycle the pointers move.
- Write while full: ignored. Memory, write_ptr and count are unchanged; no error output.
- Read while empty: ignored. data_out, read_ptr and count are unchanged.
- Simultaneous write and read:
  - empty=1: only the write is performed; empty drops next cycle.
  - full=1: only the read is performed; full drops next cycle.
  - Otherwise both are performed. count and flags are unchanged, and both pointers advance.
- No read-during-write bypass: a word written at edge N is readable no earlier than the read edge N+1.
- Order is strictly first-in first-out.

Decomposition:
- Package fifo_pkg holds:
  - default DATA_WIDTH/DEPTH localparams.
  - a data_t typedef (logic [DATA_WIDTH-1:0]) shared by the DUT, the fifo interface and the bench.
- One optional sub-module, fifo_mem: DEPTH x DATA_WIDTH register array with a synchronous write port and a registered read port.
- Pointer, count and flag logic stay in sync_fifo.

Test Plan:
- Reset check: hold reset=1 for 2 cycles, then release -> empty=1, full=0, data_out=0, write_ptr=0.
- Fill then drain: write 0x01..0x10 on consecutive cycles (DEPTH=16) -> full=1 after the 16th write.
  - Then read 16 times -> data_out returns 0x01..0x10 in order, one cycle after each read.
  - empty=1 after the last read.
- Overflow: when full, write 0xAA -> write_ptr and count unchanged, full stays 1; the next 16 reads never return 0xAA.
- Underflow: when empty, assert Read_enable for 3 cycles -> data_out holds its previous value, empty stays 1, read_ptr unchanged.
- Simultaneous read/write with 5 entries stored: both asserted for 10 cycles -> count stays 5, flags unchanged, data still in order.
  - Repeat at empty (write only, empty->0) and at full (read only, full->0).
- Wrap and reset mid-operation: write 20 and read 20 interleaved -> pointers wrap past 15->0 with correct data.
  - Then, with 7 entries stored, assert reset for 1 cycle -> empty=1, full=0, and all pointers are 0 at the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the synchronous FIFO: word type, default
// geometry and the per-cycle operation encoding used by the pointer logic.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 16;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

    // What the FIFO actually does in a cycle once full/empty gating is applied.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_t;

    function automatic fifo_op_t decode_op(input logic wr_ok, input logic rd_ok);
        return fifo_op_t'({wr_ok, rd_ok});
    endfunction

endpackage

// File: rtl/fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo; the master side drives
// requests and write data, the slave side (the FIFO) returns data and flags.
interface fifo_if;
    import fifo_pkg::*;

    logic  Wr_enable;
    logic  Read_enable;
    data_t data_in;
    data_t data_out;
    logic  full;
    logic  empty;

    modport master (
        output Wr_enable,
        output Read_enable,
        output data_in,
        input  data_out,
        input  full,
        input  empty
    );

    modport slave (
        input  Wr_enable,
        input  Read_enable,
        input  data_in,
        output data_out,
        output full,
        output empty
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array with a synchronous write port and a
// registered read port; the read register clears on reset, the array does not.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // NOTE: the array is deliberately left out of reset; stale words are never
    // visible because the pointers gate every read, and it stays a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer, occupancy count and registered full/empty flags,
// with storage and the registered read-data port held in fifo_mem.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic   clk,
    input  logic   reset,
    fifo_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    // write_ptr/read_ptr/count keep their plain names so hierarchical probes resolve.
    logic [ADDR_W-1:0]     write_ptr, write_ptr_d;
    logic [ADDR_W-1:0]     read_ptr,  read_ptr_d;
    logic [ADDR_W:0]       count,     count_d;
    logic                  full_q,    full_d;
    logic                  empty_q,   empty_d;
    logic                  wr_ok, rd_ok;
    fifo_op_t              op;
    logic [DATA_WIDTH-1:0] rd_data;

    always_comb begin
        // NOTE: every combinational output is given a default first, so no
        // branch can leave a value unassigned and infer a latch.
        wr_ok       = bus.Wr_enable   && !full_q;
        rd_ok       = bus.Read_enable && !empty_q;
        op          = decode_op(wr_ok, rd_ok);
        write_ptr_d = write_ptr;
        read_ptr_d  = read_ptr;
        count_d     = count;

        unique case (op)
            OP_WRITE: begin
                write_ptr_d = write_ptr + ADDR_W'(1);
                count_d     = count + (ADDR_W+1)'(1);
            end
            OP_READ: begin
                read_ptr_d = read_ptr + ADDR_W'(1);
                count_d    = count - (ADDR_W+1)'(1);
            end
            OP_BOTH: begin
                write_ptr_d = write_ptr + ADDR_W'(1);
                read_ptr_d  = read_ptr + ADDR_W'(1);
            end
            default: ;
        endcase

        // Flags come from the next count so they move with the pointers.
        full_d  = (count_d == FULL_COUNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so each one
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            write_ptr <= write_ptr_d;
            read_ptr  <= read_ptr_d;
            count     <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_ok && !reset),
        .wr_addr_i (write_ptr),
        .wr_data_i (bus.data_in),
        .rd_en_i   (rd_ok),
        .rd_addr_i (read_ptr),
        .rd_data_o (rd_data)
    );

    assign bus.data_out = rd_data;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed and random traffic compared each
// cycle against a queue-based reference of FIFO behaviour.
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int DEPTH = DEFAULT_DEPTH;

    logic clk;
    logic reset;
    fifo_if bus ();

    sync_fifo #(
        .DATA_WIDTH (DEFAULT_DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the stored words in order, the last word read, and
    // the number of accepted writes/reads since reset (pointers are these mod DEPTH).
    data_t q[$];
    data_t m_dout;
    int    m_writes;
    int    m_reads;

    int total;
    int passes;
    int fails;
    int cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s @cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        check("empty",     32'(bus.empty),     32'(q.size() == 0));
        check("full",      32'(bus.full),      32'(q.size() == DEPTH));
        check("data_out",  32'(bus.data_out),  32'(m_dout));
        check("write_ptr", 32'(dut.write_ptr), 32'(m_writes % DEPTH));
        check("read_ptr",  32'(dut.read_ptr),  32'(m_reads % DEPTH));
        check("count",     32'(dut.count),     32'(q.size()));
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input logic we, input logic re, input data_t din, input logic rst);
        logic acc_w, acc_r;
        bus.Wr_enable   = we;
        bus.Read_enable = re;
        bus.data_in     = din;
        reset           = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            q.delete();
            m_dout   = '0;
            m_writes = 0;
            m_reads  = 0;
        end else begin
            acc_w = we && (q.size() < DEPTH);
            acc_r = re && (q.size() > 0);
            if (acc_r) begin
                m_dout = q.pop_front();
                m_reads++;
            end
            if (acc_w) begin
                q.push_back(din);
                m_writes++;
            end
        end
        check_all();
    endtask

    function automatic data_t rnd_data();
        return data_t'($urandom);
    endfunction

    initial begin
        total = 0; passes = 0; fails = 0; cyc = 0;
        m_dout = '0; m_writes = 0; m_reads = 0;
        bus.Wr_enable = 1'b0; bus.Read_enable = 1'b0; bus.data_in = '0;
        reset = 1'b1;

        // Reset held two cycles with requests that must be ignored.
        cycle(1'b1, 1'b1, rnd_data(), 1'b1);
        cycle(1'b1, 1'b0, rnd_data(), 1'b1);
        cycle(1'b0, 1'b0, rnd_data(), 1'b0);

        // Fill with 0x01..0x10, then an overflow attempt.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, data_t'(i + 1), 1'b0);
        cycle(1'b1, 1'b0, 8'hAA, 1'b0);
        // Drain completely; 0xAA must never appear.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, rnd_data(), 1'b0);
        // Underflow: data_out and read_ptr hold.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rnd_data(), 1'b0);

        // Simultaneous at empty: write only.
        cycle(1'b1, 1'b1, rnd_data(), 1'b0);
        // Bring occupancy to 5, then 10 cycles of read+write.
        while (q.size() < 5) cycle(1'b1, 1'b0, rnd_data(), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, rnd_data(), 1'b0);
        // Fill, then simultaneous at full: read only.
        while (q.size() < DEPTH) cycle(1'b1, 1'b0, rnd_data(), 1'b0);
        cycle(1'b1, 1'b1, rnd_data(), 1'b0);
        while (q.size() > 0) cycle(1'b0, 1'b1, rnd_data(), 1'b0);

        // Interleaved 20 writes / 20 reads, wrapping both pointers.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, rnd_data(), 1'b0);
            cycle(1'b0, 1'b1, rnd_data(), 1'b0);
        end

        // Random traffic, biased at times toward filling or draining.
        for (int i = 0; i < 400; i++) begin
            logic we, re;
            if (i < 100) begin
                we = ($urandom_range(0, 3) != 0);
                re = ($urandom_range(0, 3) == 0);
            end else if (i < 200) begin
                we = ($urandom_range(0, 3) == 0);
                re = ($urandom_range(0, 3) != 0);
            end else begin
                we = 1'($urandom_range(0, 1));
                re = 1'($urandom_range(0, 1));
            end
            cycle(we, re, rnd_data(), 1'b0);
        end

        // Reset mid-operation with 7 entries stored.
        while (q.size() != 7) cycle(q.size() < 7, q.size() > 7, rnd_data(), 1'b0);
        cycle(1'b1, 1'b1, rnd_data(), 1'b1);
        // Operation resumes cleanly after reset.
        cycle(1'b1, 1'b0, 8'h5C, 1'b0);
        cycle(1'b0, 1'b1, rnd_data(), 1'b0);
        cycle(1'b0, 1'b0, rnd_data(), 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
